arbitro_serial_uc: RTL and testbench
====================================

Name: arbitro_serial_uc

Overview:
- Round-robin controller that shares the single UART transmitter among N_REQ report sources (sensor measurement units, game-status unit).
- Grants one requester at a time and sequences its FRAME_BYTES-byte frame through the transmitter, one `partida_tx`/`pronto_tx` handshake per byte.
- Acknowledges the requester when its frame is complete, and aborts on transmitter timeout.
- Sits between the measurement/control units and the serial TX block.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- FRAME_BYTES, 4, bytes per frame (2..4).
- TIMEOUT_CYC, 100000, maximum clock cycles to wait for `pronto_tx` per byte.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its ack or erro.
- dado_req  in  8*N_REQ  byte from each requester, selected by byte_idx; requester i drives bits [8i+7:8i].
- pronto_tx  in  1  transmitter one-cycle pulse: current byte finished.
- grant  out  N_REQ  one-hot owner of the transmitter; all zero when idle.
- byte_idx  out  2  index of the byte currently requested from the owner.
- dado_tx  out  8  byte to transmit.
- partida_tx  out  1  one-cycle start pulse to the transmitter.
- ack  out  N_REQ  one-cycle pulse on the owner's bit when its frame is complete.
- erro  out  1  one-cycle pulse when a frame is aborted by timeout.
- db_estado  out  3  debug state code.

Behaviour:
- Reset: state OCIOSO; grant=0, byte_idx=0, partida_tx=0, ack=0, erro=0, timeout counter=0, priority pointer ptr=N_REQ-1 (requester 0 has first priority).
- All outputs are Moore, decoded from registered state and registers. dado_tx is combinational: the byte of dado_req belonging to the granted requester, or 0 when grant=0.
- OCIOSO (000):
  - If any req bit is set, select the first set bit searching circularly from ptr+1.
  - On that edge: load grant one-hot, set byte_idx=0, go to CARREGA. Otherwise stay.
- CARREGA (001): partida_tx=1 for exactly this cycle; clear the timeout counter; go to ESPERA.
- ESPERA (010):
  - Increment the timeout counter each cycle.
  - pronto_tx=1 → PROXIMO. pronto_tx has priority over timeout in the same cycle.
  - Counter reaching TIMEOUT_CYC-1 without pronto_tx → ERRO.
- PROXIMO (011):
  - If byte_idx == FRAME_BYTES-1 → FIM.
  - Otherwise byte_idx increments and the state returns to CARREGA.
- FIM (100):
  - ack[owner]=1 for one cycle; ptr ← owner index.
  - On the next edge grant is cleared and byte_idx returns to 0; go to OCIOSO.
- ERRO (101):
  - erro=1 for one cycle; no ack; ptr ← owner index, so a faulty requester cannot starve the others.
  - On the next edge grant and byte_idx are cleared; go to OCIOSO.
- Unused codes: db_estado=111; the next state is OCIOSO.
- Latency:
  - req seen in OCIOSO → grant visible next cycle, same cycle as partida_tx.
  - Minimum cycles per byte = 3 + wait for pronto_tx.
  - Minimum OCIOSO-to-ack time = 1 + FRAME_BYTES*(3+w) cycles, where w is the pronto_tx wait.
- The frame is not interruptible. A req drop, or a new higher-priority req, while a frame is in progress is ignored until FIM/ERRO.
- After FIM or ERRO the arbiter returns to OCIOSO before the next grant, so there is one idle cycle between frames.
- pronto_tx outside ESPERA is ignored.
- The owner must hold its byte for byte_idx stable from CARREGA until pronto_tx.
- Asynchronous reset mid-frame drops the frame silently (no ack, no erro) and forces the reset values above.

Test Plan:
- Single request: req=001, dado_req[7:0] returns 0xA0+byte_idx, pronto_tx pulses 5 cycles after each partida_tx → four partida_tx pulses with dado_tx=A0,A1,A2,A3; exactly one ack=001 pulse; grant=001 throughout; then grant=000.
- Simultaneous requests: req=111 held from reset → frames served in order 0,1,2. Re-asserting req0 right after its ack is served after requester 2, not before.
- Priority rotation: requester 1 served, then req=011 → requester 0 is granted next (search starts at ptr+1=2, wraps to 0).
- Timeout: TIMEOUT_CYC=20, pronto_tx never pulses → erro pulses 21 cycles after the first partida_tx; no ack; grant returns to 0; the next pending requester is served.
- Stray and concurrent events: pronto_tx pulsed in OCIOSO and in CARREGA → ignored. pronto_tx on the timeout cycle → treated as byte done, no erro.
- Reset mid-frame: assert reset during byte 2 → next cycle grant=0, byte_idx=0, db_estado=000, no ack/erro. After reset is released, a still-asserted req restarts from byte 0.

Source files
------------

// File: rtl/arbitro_serial_uc_if.sv
// arbitro_serial_uc_if: request/transmit bus between report sources, arbiter and UART TX
interface arbitro_serial_uc_if #(parameter int N_REQ = 3);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] dado_req;
    logic               pronto_tx;
    logic [N_REQ-1:0]   grant;
    logic [1:0]         byte_idx;
    logic [7:0]         dado_tx;
    logic               partida_tx;
    logic [N_REQ-1:0]   ack;
    logic               erro;
    logic [2:0]         db_estado;
    modport master (
        input  req, dado_req, pronto_tx,
        output grant, byte_idx, dado_tx, partida_tx, ack, erro, db_estado
    );
    modport slave (
        output req, dado_req, pronto_tx,
        input  grant, byte_idx, dado_tx, partida_tx, ack, erro, db_estado
    );
endinterface

// File: rtl/arbitro_serial_uc.sv
// arbitro_serial_uc: round-robin arbiter sharing one UART transmitter among N_REQ frame sources
module arbitro_serial_uc #(
    parameter int N_REQ       = 3,
    parameter int FRAME_BYTES = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clock,
    input  logic                reset,
    arbitro_serial_uc_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        OCIOSO  = 3'b000,
        CARREGA = 3'b001,
        ESPERA  = 3'b010,
        PROXIMO = 3'b011,
        FIM     = 3'b100,
        ERRO    = 3'b101
    } estado_t;

    estado_t          estado;
    logic [N_REQ-1:0] grant;
    logic [1:0]       byte_idx;
    logic [1:0]       ptr;
    logic [1:0]       dono;
    logic [1:0]       sel;
    logic             sel_ok;
    logic [CW-1:0]    cnt;

    function automatic logic [1:0] circ(input logic [1:0] p, input int k);
        return 2'((int'(p) + k) % N_REQ);
    endfunction

    // scan from farthest to nearest so the first requester after ptr wins
    always_comb begin
        sel_ok = 1'b0;
        sel    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.req[circ(ptr, k)]) begin
                sel_ok = 1'b1;
                sel    = circ(ptr, k);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            grant    <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            ptr      <= 2'(N_REQ - 1);
            dono     <= '0;
        end else begin
            case (estado)
                OCIOSO: if (sel_ok) begin
                    grant    <= N_REQ'(1) << sel;
                    dono     <= sel;
                    byte_idx <= '0;
                    estado   <= CARREGA;
                end
                CARREGA: begin
                    cnt    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    cnt <= cnt + CW'(1);
                    if (bus.pronto_tx) estado <= PROXIMO;
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) estado <= ERRO;
                end
                PROXIMO: if (byte_idx == 2'(FRAME_BYTES - 1)) estado <= FIM;
                else begin
                    byte_idx <= byte_idx + 2'd1;
                    estado   <= CARREGA;
                end
                // owner drops to lowest priority whether it finished or timed out
                FIM, ERRO: begin
                    ptr      <= dono;
                    grant    <= '0;
                    byte_idx <= '0;
                    estado   <= OCIOSO;
                end
                default: begin
                    grant    <= '0;
                    byte_idx <= '0;
                    estado   <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.grant      = grant;
    assign bus.byte_idx   = byte_idx;
    assign bus.partida_tx = estado == CARREGA;
    assign bus.ack        = estado == FIM ? grant : '0;
    assign bus.erro       = estado == ERRO;
    assign bus.db_estado  = estado > ERRO ? 3'b111 : estado;
    assign bus.dado_tx    = |grant ? bus.dado_req[{dono, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_arbitro_serial_uc.sv
// tb_arbitro_serial_uc: directed plus randomized frames checked against a transaction-level model
module tb_arbitro_serial_uc;
    localparam int N   = 3;
    localparam int FB  = 4;
    localparam int TMO = 20;

    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int m_ptr = N - 1;
    logic [7:0] base [N];

    arbitro_serial_uc_if #(.N_REQ(N)) bus ();

    arbitro_serial_uc #(.N_REQ(N), .FRAME_BYTES(FB), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive_bytes(input int k);
        for (int i = 0; i < N; i++) bus.dado_req[8*i +: 8] = 8'(base[i] + 8'(k));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, bus.db_estado, 0);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_byte_idx"}, bus.byte_idx, 0);
        chk({tag, "_ack"}, bus.ack, 0);
        chk({tag, "_erro"}, bus.erro, 0);
        chk({tag, "_partida"}, bus.partida_tx, 0);
    endtask

    // w<0: random wait per byte; tmo_k: byte that never gets pronto; rst_k: byte reset hits
    task automatic serve(input int o, input int w, input int tmo_k, input int rst_k);
        logic [N-1:0] g;
        int ww;
        g = '0;
        g[o] = 1'b1;
        for (int k = 0; k < FB; k++) begin
            drive_bytes(k);
            tick();
            chk("carrega_state", bus.db_estado, 1);
            chk("partida", bus.partida_tx, 1);
            chk("grant", bus.grant, g);
            chk("byte_idx", bus.byte_idx, k);
            chk("dado_tx", bus.dado_tx, 8'(base[o] + 8'(k)));
            if ($urandom_range(0, 3) == 0) bus.req = bus.req | N'($urandom);
            bus.pronto_tx = 1'($urandom_range(0, 1));
            tick();
            bus.pronto_tx = 1'b0;
            chk("espera_state", bus.db_estado, 2);
            chk("partida_off", bus.partida_tx, 0);
            if (rst_k == k) begin
                reset = 1'b1;
                #1;
                chk_idle("rst_async");
                @(negedge clock);
                chk_idle("rst_held");
                reset = 1'b0;
                m_ptr = N - 1;
                return;
            end
            if (tmo_k == k) begin
                repeat (TMO - 1) begin
                    tick();
                    chk("tmo_wait", bus.db_estado, 2);
                    chk("tmo_erro_early", bus.erro, 0);
                end
                tick();
                chk("erro_state", bus.db_estado, 5);
                chk("erro_pulse", bus.erro, 1);
                chk("erro_no_ack", bus.ack, 0);
                chk("erro_grant", bus.grant, g);
                bus.req[o] = 1'b0;
                m_ptr = o;
                tick();
                chk_idle("after_erro");
                return;
            end
            ww = w < 0 ? int'($urandom_range(0, TMO - 1)) : w;
            repeat (ww) begin
                tick();
                chk("espera_wait", bus.db_estado, 2);
                chk("dado_hold", bus.dado_tx, 8'(base[o] + 8'(k)));
            end
            bus.pronto_tx = 1'b1;
            tick();
            bus.pronto_tx = 1'b0;
            chk("proximo_state", bus.db_estado, 3);
            chk("proximo_erro", bus.erro, 0);
        end
        tick();
        chk("fim_state", bus.db_estado, 4);
        chk("ack", bus.ack, g);
        chk("fim_erro", bus.erro, 0);
        chk("fim_grant", bus.grant, g);
        bus.req[o] = 1'b0;
        m_ptr = o;
        tick();
        chk_idle("after_fim");
    endtask

    task automatic serve_next(input int w, input int tmo_k);
        int o;
        o = pick(bus.req, m_ptr);
        if (o < 0) begin
            failures++;
            $error("FAIL serve_next observed=no_request expected=pending_request");
            return;
        end
        serve(o, w, tmo_k, -1);
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.dado_req = '0;
        bus.pronto_tx = 1'b0;
        for (int i = 0; i < N; i++) base[i] = 8'($urandom);
        @(negedge clock);
        chk_idle("reset");
        reset = 1'b0;
        bus.pronto_tx = 1'b1;
        tick();
        bus.pronto_tx = 1'b0;
        chk_idle("stray_ocioso");

        base[0] = 8'hA0;
        bus.req = 3'b001;
        serve(0, 4, -1, -1);

        reset = 1'b1;
        bus.req = 3'b111;
        tick();
        reset = 1'b0;
        m_ptr = N - 1;
        for (int i = 0; i < N; i++) base[i] = 8'($urandom);
        serve_next(-1, -1);
        bus.req[0] = 1'b1;
        repeat (3) serve_next(-1, -1);

        bus.req = 3'b010;
        serve_next(-1, -1);
        bus.req = 3'b011;
        serve_next(-1, -1);
        serve_next(TMO - 1, -1);

        bus.req = 3'b101;
        serve_next(-1, 0);
        serve_next(-1, -1);

        bus.req = 3'b001;
        serve(0, 2, -1, 2);
        serve_next(-1, -1);

        repeat (30) begin
            if (bus.req == '0) bus.req = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) base[i] = 8'($urandom);
            serve_next(-1, $urandom_range(0, 7) == 0 ? int'($urandom_range(0, FB - 1)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
